// File: rtl/aes_stream_loader_if.sv
// Host-side word stream bundle for aes_stream_loader: 32-bit input words in, 32-bit result words out.
// master = host/bench side, slave = loader side.
interface aes_stream_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes_stream_loader.sv
// Purpose: gathers header/key/data words for aes_core, pulses load, returns the 128-bit result as 4 words.
// Latency: load 1 cycle after the last data word, then ARM + WAIT; optional AES_TRIGGER_EN drives trigger_o.
// Backpressure: in_ready is low outside header/key/data phases; out_data/out_last hold while out_ready is low.
module aes_stream_loader #(
    parameter int WAIT_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_stream_loader_if.slave   bus,
    output logic                 err_o,
    output logic                 trigger_o,
    output logic                 core_load_o,
    output logic [255:0]         core_key_o,
    output logic [127:0]         core_data_o,
    output logic [1:0]           core_size_o,
    output logic                 core_dec_o,
    input  logic [127:0]         core_data_i,
    input  logic                 core_busy_i
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_DATA, S_LOAD, S_ARM, S_WAIT, S_OUT
    } state_t;

    state_t         r_state, w_next;
    logic [255:0]   r_key;
    logic [127:0]   r_data;
    logic [127:0]   r_result;
    logic [1:0]     r_size;
    logic           r_dec;
    logic           r_err;
    logic [2:0]     r_key_cnt;
    logic [1:0]     r_data_cnt;
    logic [1:0]     r_out_cnt;
    logic [CW-1:0]  r_wait_cnt;

    logic           w_in_ready, w_out_valid, w_load;
    logic           w_in_fire, w_out_fire;
    logic [2:0]     w_key_last_idx;
    logic           w_key_last, w_timeout, w_wait_done;
    logic [31:0]    w_out_word;

    assign w_in_fire      = bus.in_valid && w_in_ready;
    assign w_out_fire     = w_out_valid && bus.out_ready;
    assign w_key_last_idx = (r_size == 2'd0) ? 3'd3 : (r_size == 2'd1) ? 3'd5 : 3'd7;
    assign w_key_last     = (r_key_cnt == w_key_last_idx);
    // Capture has priority: a timeout only counts while busy is still high.
    assign w_timeout      = core_busy_i && (r_wait_cnt == CW'(WAIT_MAX - 1));
    assign w_wait_done    = !core_busy_i || w_timeout;
    assign w_out_word     = r_result[{~r_out_cnt, 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (w_in_fire) w_next = S_KEY;
            end
            S_KEY: begin
                w_in_ready = 1'b1;
                if (w_in_fire && w_key_last) w_next = S_DATA;
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                if (w_in_fire && r_data_cnt == 2'd3) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_ARM;
            end
            S_ARM:  w_next = S_WAIT;
            S_WAIT: if (w_wait_done) w_next = S_OUT;
            S_OUT: begin
                w_out_valid = 1'b1;
                if (w_out_fire && r_out_cnt == 2'd3) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key      <= '0;
            r_data     <= '0;
            r_result   <= '0;
            r_size     <= '0;
            r_dec      <= 1'b0;
            r_err      <= 1'b0;
            r_key_cnt  <= '0;
            r_data_cnt <= '0;
            r_out_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_size     <= bus.in_data[1:0];
                    r_dec      <= bus.in_data[2];
                    r_key      <= '0;
                    r_data     <= '0;
                    r_err      <= 1'b0;
                    r_key_cnt  <= '0;
                    r_data_cnt <= '0;
                end
                S_KEY: if (w_in_fire) begin
                    r_key[{~r_key_cnt, 5'b0} +: 32] <= bus.in_data;
                    if (!w_key_last) r_key_cnt <= r_key_cnt + 3'd1;
                end
                S_DATA: if (w_in_fire) begin
                    r_data[{~r_data_cnt, 5'b0} +: 32] <= bus.in_data;
                    if (r_data_cnt != 2'd3) r_data_cnt <= r_data_cnt + 2'd1;
                end
                S_ARM: r_wait_cnt <= '0;
                S_WAIT: begin
                    if (!core_busy_i) begin
                        r_result  <= core_data_i;
                        r_out_cnt <= '0;
                    end else if (w_timeout) begin
                        r_result  <= '0;
                        r_err     <= 1'b1;
                        r_out_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_OUT: if (w_out_fire && r_out_cnt != 2'd3) r_out_cnt <= r_out_cnt + 2'd1;
                default: ;
            endcase
        end
    end

`ifdef AES_TRIGGER_EN
    logic r_trigger;
    // High from the cycle after LOAD through the capture/timeout cycle.
    always_ff @(posedge clk) begin
        if (reset)                                r_trigger <= 1'b0;
        else if (r_state == S_LOAD)               r_trigger <= 1'b1;
        else if (r_state == S_WAIT && w_wait_done) r_trigger <= 1'b0;
    end
    assign trigger_o = r_trigger;
`else
    assign trigger_o = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_out_word : 32'h0;
    assign bus.out_last  = w_out_valid && (r_out_cnt == 2'd3);
    assign err_o         = r_err;
    assign core_load_o   = w_load;
    assign core_key_o    = r_key;
    assign core_data_o   = r_data;
    assign core_size_o   = r_size;
    assign core_dec_o    = r_dec;
endmodule
